// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and a held result for writeback.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_a_q, neg_b_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     result_q;

    logic                a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]     abs_a, abs_b;

    always_comb begin
        a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        neg_a    = a_signed & rs1[XLEN-1];
        neg_b    = b_signed & rs2[XLEN-1];
        // Magnitude of the most negative value wraps to itself, read as unsigned 2^(XLEN-1).
        abs_a    = neg_a ? -rs1 : rs1;
        abs_b    = neg_b ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                   (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    end

    // acc_q holds {product hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (op_q[2]) begin
            if (div_diff[XLEN])
                acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'd0)
            fix_res = prod_fix[XLEN-1:0];
        else
            fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q    <= funct3;
                    neg_a_q <= neg_a;
                    neg_b_q <= neg_b;
                    cnt_q   <= '0;
                    opb_q   <= funct3[2] ? abs_b : abs_a;
                    acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
                    if (div_zero) begin
                        result_q <= funct3[1] ? rs1 : '1;
                        state_q  <= DONE;
                    end else if (div_ovf) begin
                        result_q <= funct3[1] ? '0 : rs1;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1))
                        state_q <= FIX;
                end
                FIX: begin
                    result_q <= fix_res;
                    state_q  <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + random bench for muldiv_seq with a result scoreboard and latency checks.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbs, sbu;
        logic [63:0] p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sbs = {{32{b[31]}}, b};
        sbu = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sbs; return p[31:0]; end
            3'd1: begin p = sa * sbs; return p[63:32]; end
            3'd2: begin p = sa * sbu; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Present a request at a negedge; it is accepted on the following posedge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); @(negedge clk); n++; end
        check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        funct3 = f; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency counts edges from the accept edge (inclusive) to the first sample with out_valid high.
    task automatic wait_valid(input int lat_exp);
        int lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); @(negedge clk); lat++; end
        check("latency", 32'(lat), 32'(lat_exp));
    endtask

    task automatic finish_op(input string tag);
        logic [31:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check(tag, result, exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_drop", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        sb.push_back(exp);
        start_op(f, a, b);
        wait_valid(exp_lat(f, a, b));
        finish_op(tag);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb, hold_exp;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = '0; rs1 = '0; rs2 = '0;
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_result",    result,             32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        do_op("mul_neg",    3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);
        do_op("mulh_neg",   3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
        do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_neg",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        do_op("rem_neg",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        do_op("divu",       3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
        do_op("divu_zero",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
        do_op("rem_zero",   3'd6, 32'd5,         32'd0,         32'd5);
        do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op("mulh_minsq", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("div_min_by2",3'd4, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000);

        // Backpressure: result held, no acceptance while waiting on writeback.
        hold_exp = 32'h0000_0015;
        sb.push_back(hold_exp);
        out_ready = 1'b0;
        start_op(3'd0, 32'd7, 32'd3);
        wait_valid(34);
        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd9; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_result",    result,             hold_exp);
            check("bp_in_ready",  {31'b0, in_ready},  32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        finish_op("bp_final");
        check("bp_idle", {31'b0, in_ready}, 32'd1);
        do_op("after_bp", 3'd7, 32'd100, 32'd9, 32'd1);

        // Flush at CALC count=10; the aborted request never reaches the scoreboard.
        start_op(3'd4, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); @(negedge clk); flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_busy",     {31'b0, busy},     32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            check("flush_no_valid", {31'b0, out_valid}, 32'd0);
        end
        // Flush takes priority over a same-cycle request in IDLE.
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drop_req", {31'b0, busy}, 32'd0);
        do_op("after_flush", 3'd4, 32'd1000, 32'd7, 32'd142);

        // Asynchronous reset mid-CALC.
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'b0, in_ready},  32'd1);
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_busy",      {31'b0, busy},      32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_op("after_rst", 3'd6, 32'd17, 32'hFFFF_FFFB, 32'd2);

        for (int i = 0; i < 12; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = rb >> $urandom_range(0, 31);
            do_op("random", rf, ra, rb, model(rf, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
